// File: rtl/sp_mem_ctrl.sv
// sp_mem_ctrl: burst controller in front of single_port_mem.
// Sequences write and read bursts onto the memory's wr_en/rd/address pins,
// owns the shared data bus while writing, and returns read beats through a
// 2-entry skid buffer with valid/ready flow control.
// Optional feature macro: SPMEM_CTRL_STATS_EN adds saturating beat counters
// (outputs wr_beats and rd_beats).
module sp_mem_ctrl #(
   parameter int LEN_W  = 8,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DATA_W-1:0] wdata,
   output logic              rdata_valid,
   input  logic              rdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_last,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_en,
   output logic              mem_rd,
`ifdef SPMEM_CTRL_STATS_EN
   output logic [15:0]       wr_beats,
   output logic [15:0]       rd_beats,
`endif
   inout  wire  [DATA_W-1:0] mem_data_io
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WR    = 2'd1,
      S_RD    = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   // Burst bookkeeping: r_remain holds beats still to issue minus one, so a
   // full-length burst (2**LEN_W beats) fits without widening the counter.
   logic [ADDR_W-1:0]   r_addr;
   logic [LEN_W-1:0]    r_remain;

   // A read issued last cycle: memory is driving the bus this cycle.
   logic                r_inflight;
   logic                r_inflight_last;

   // Skid buffer storage and pointers.
   logic [DATA_W-1:0]   r_skid_data [2];
   logic                r_skid_last [2];
   logic                r_wptr;
   logic                r_rptr;
   logic [1:0]          r_count;

   logic                w_load;
   logic                w_wr_fire;
   logic                w_rd_fire;
   logic                w_pop;
   logic                w_push;
   logic                w_last_beat;
   logic [2:0]          w_occupancy;

   assign w_pop       = (r_count != 2'd0) && rdata_ready;
   assign w_push      = r_inflight;
   assign w_last_beat = (r_remain == '0);

   // Credit seen by the read issuer: beats that will still be buffered after
   // this cycle's pop, plus the beat currently on the bus. Counting the pop
   // lets a continuously-ready consumer sustain one beat per cycle.
   assign w_occupancy = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_inflight};

   // Next-state and handshake decode; memory strobes are forced low during
   // reset so the memory's bus driver is guaranteed off afterwards.
   always_comb begin
      w_state_next = r_state;
      cmd_ready    = 1'b0;
      wdata_ready  = 1'b0;
      w_load       = 1'b0;
      w_wr_fire    = 1'b0;
      w_rd_fire    = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_load       = 1'b1;
               w_state_next = cmd_write ? S_WR : S_RD;
            end
         end
         S_WR: begin
            wdata_ready = 1'b1;
            if (wdata_valid) begin
               w_wr_fire = 1'b1;
               if (w_last_beat) begin
                  w_state_next = S_IDLE;
               end
            end
         end
         S_RD: begin
            if (w_occupancy < 3'd2) begin
               w_rd_fire = 1'b1;
               if (w_last_beat) begin
                  w_state_next = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (!r_inflight) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign mem_wr_en   = w_wr_fire && !reset;
   assign mem_rd      = w_rd_fire && !reset;
   assign mem_addr    = r_addr;
   assign mem_data_io = mem_wr_en ? wdata : {DATA_W{1'bz}};

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Address counter and remaining-beat counter; the address wraps freely.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr   <= '0;
         r_remain <= '0;
      end else if (w_load) begin
         r_addr   <= cmd_addr;
         r_remain <= cmd_len;
      end else if (w_wr_fire || w_rd_fire) begin
         r_addr <= r_addr + 1'b1;
         if (!w_last_beat) begin
            r_remain <= r_remain - 1'b1;
         end
      end
   end

   // Track the read that memory will answer next cycle and whether it is the last.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         r_inflight      <= w_rd_fire;
         r_inflight_last <= w_rd_fire && w_last_beat;
      end
   end

   // Skid buffer: capture the bus during an in-flight cycle, pop on handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            r_skid_data[i] <= '0;
            r_skid_last[i] <= 1'b0;
         end
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push) begin
            r_skid_data[r_wptr] <= mem_data_io;
            r_skid_last[r_wptr] <= r_inflight_last;
            r_wptr              <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign rdata_valid = (r_count != 2'd0);
   assign rdata       = r_skid_data[r_rptr];
   assign rdata_last  = rdata_valid && r_skid_last[r_rptr];
   assign busy        = (r_state != S_IDLE) || rdata_valid;

`ifdef SPMEM_CTRL_STATS_EN
   logic [15:0] r_wr_beats;
   logic [15:0] r_rd_beats;

   // Saturating counts of memory write and read strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_beats <= '0;
         r_rd_beats <= '0;
      end else begin
         if (mem_wr_en && (r_wr_beats != 16'hFFFF)) begin
            r_wr_beats <= r_wr_beats + 16'd1;
         end
         if (mem_rd && (r_rd_beats != 16'hFFFF)) begin
            r_rd_beats <= r_rd_beats + 16'd1;
         end
      end
   end

   assign wr_beats = r_wr_beats;
   assign rd_beats = r_rd_beats;
`endif

endmodule

// File: tb/tb_sp_mem_ctrl.sv
// tb_sp_mem_ctrl: scoreboard bench for sp_mem_ctrl with a behavioural
// single-port memory (read data driven one cycle after rd).
module tb_sp_mem_ctrl;
   localparam int LEN_W  = 8;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_write = 1'b0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [LEN_W-1:0]  cmd_len = '0;
   logic              wdata_valid = 1'b0;
   logic              wdata_ready;
   logic [DATA_W-1:0] wdata = '0;
   logic              rdata_valid;
   logic              rdata_ready = 1'b1;
   logic [DATA_W-1:0] rdata;
   logic              rdata_last;
   logic              busy;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wr_en;
   logic              mem_rd;
   wire  [DATA_W-1:0] mem_data_io;
`ifdef SPMEM_CTRL_STATS_EN
   logic [15:0]       wr_beats;
   logic [15:0]       rd_beats;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int wr_pulses = 0;
   int first_rd  = -1;
   int first_val = -1;
   int last_val  = -1;

   logic [16:0] rq [$];   // {last, data}
   logic [25:0] wq [$];   // {addr, data}

   always #5 clk = ~clk;

   sp_mem_ctrl #(.LEN_W(LEN_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
      .rdata_last(rdata_last), .busy(busy),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd(mem_rd),
`ifdef SPMEM_CTRL_STATS_EN
      .wr_beats(wr_beats), .rd_beats(rd_beats),
`endif
      .mem_data_io(mem_data_io)
   );

   // Behavioural single-port memory
   logic [DATA_W-1:0] m_mem [0:1023] = '{default: 16'h0000};
   logic [DATA_W-1:0] m_q = '0;
   logic              m_drv = 1'b0;
   int                m_occ = 0;

   assign mem_data_io = m_drv ? m_q : 16'hzzzz;

   always @(posedge clk) begin
      if (mem_wr_en) m_mem[mem_addr] <= mem_data_io;
      if (mem_rd) m_q <= m_mem[mem_addr];
      m_drv <= mem_rd;
      cyc   <= cyc + 1;
      if (reset) m_occ <= 0;
      else m_occ <= m_occ + (m_drv ? 1 : 0) - ((rdata_valid && rdata_ready) ? 1 : 0);
   end

   // Monitor: pops scoreboards and checks bus/credit rules at mid-cycle
   always @(negedge clk) begin
      logic [16:0] er;
      logic [25:0] ew;
      int eff;
      if (rdata_valid && rdata_ready) begin
         checks++;
         if (first_val < 0) first_val = cyc;
         last_val = cyc;
         if (rq.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected got data=%h last=%0b required none", rdata, rdata_last);
         end else begin
            er = rq.pop_front();
            if ({rdata_last, rdata} !== er) begin
               failures++;
               $display("FAIL rd_beat got data=%h last=%0b required data=%h last=%0b",
                        rdata, rdata_last, er[15:0], er[16]);
            end else begin
               $display("rd beat data=%h last=%0b", rdata, rdata_last);
            end
         end
      end
      if (mem_wr_en) begin
         wr_pulses++;
         checks++;
         if (wq.size() == 0) begin
            failures++;
            $display("FAIL wr_unexpected got addr=%h data=%h required none", mem_addr, mem_data_io);
         end else begin
            ew = wq.pop_front();
            if ({mem_addr, mem_data_io} !== ew) begin
               failures++;
               $display("FAIL wr_beat got addr=%h data=%h required addr=%h data=%h",
                        mem_addr, mem_data_io, ew[25:16], ew[15:0]);
            end else begin
               $display("wr beat addr=%h data=%h", mem_addr, mem_data_io);
            end
         end
         checks++;
         if (m_drv) begin
            failures++;
            $display("FAIL bus_conflict got wr_en=1 with memory driving required no overlap");
         end
      end
      if (mem_rd) begin
         if (first_rd < 0) first_rd = cyc;
         eff = m_occ - ((rdata_valid && rdata_ready) ? 1 : 0) + (m_drv ? 1 : 0);
         checks++;
         if (eff >= 2) begin
            failures++;
            $display("FAIL rd_credit got occupancy=%0d at issue required <2", eff);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
      int n;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_len   = l;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         checks++;
         failures++;
         $display("FAIL cmd_timeout got cmd_ready=0 required 1");
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      $display("cmd write=%0b addr=%h len=%0d", w, a, l);
   endtask

   task automatic write_beat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int n;
      wq.push_back({a, d});
      wdata_valid = 1'b1;
      wdata       = d;
      n = 0;
      @(negedge clk);
      while (!wdata_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!wdata_ready) begin
         checks++;
         failures++;
         $display("FAIL wdata_timeout got wdata_ready=0 required 1");
      end
      @(posedge clk);
      #1;
      wdata_valid = 1'b0;
   endtask

   task automatic write_burst(input logic [ADDR_W-1:0] a, input int l,
                              input logic [DATA_W-1:0] base, input int gap_at);
      logic [ADDR_W-1:0] ad;
      send_cmd(1'b1, a, LEN_W'(l));
      for (int i = 0; i <= l; i++) begin
         if (i == gap_at) tick();
         ad = a + ADDR_W'(i);
         write_beat(ad, base + DATA_W'(i));
      end
   endtask

   task automatic push_rd(input logic [DATA_W-1:0] d, input logic last);
      rq.push_back({last, d});
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || rq.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy || rq.size() != 0) begin
         failures++;
         $display("FAIL idle_timeout got busy=%0b pending=%0d required idle", busy, rq.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr0;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
      chk("rst_mem_rd", 32'(mem_rd), 32'h0);
      chk("rst_rdata_valid", 32'(rdata_valid), 32'h0);
      chk("rst_rdata_last", 32'(rdata_last), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      tick();

      // 1: write len=3 at 0x3FE, wrapping address
      wr0 = wr_pulses;
      write_burst(10'h3FE, 3, 16'h00A0, -1);
      chk("t1_idle_cmd_ready", 32'(cmd_ready), 32'h1);
      chk("t1_idle_busy", 32'(busy), 32'h0);
      chk("t1_wr_pulses", 32'(wr_pulses - wr0), 32'd4);

      // 2: read len=3 at 0x3FE, streaming
      first_rd = -1; first_val = -1; last_val = -1;
      push_rd(16'h00A0, 1'b0); push_rd(16'h00A1, 1'b0);
      push_rd(16'h00A2, 1'b0); push_rd(16'h00A3, 1'b1);
      send_cmd(1'b0, 10'h3FE, 8'd3);
      wait_idle();
      chk("t2_first_latency", 32'(first_val - first_rd), 32'd2);
      chk("t2_stream_span", 32'(last_val - first_val), 32'd3);

      // 3: write len=7 with a gap, then read len=7 with toggling ready
      write_burst(10'h100, 7, 16'hB000, 3);
      for (int i = 0; i < 8; i++) push_rd(16'hB000 + 16'(i), i == 7);
      send_cmd(1'b0, 10'h100, 8'd7);
      for (int n = 0; n < 300 && (busy || rq.size() != 0); n++) begin
         rdata_ready = ~rdata_ready;
         tick();
      end
      rdata_ready = 1'b1;
      chk("t3_all_beats", 32'(rq.size()), 32'd0);
      wait_idle();

      // 4: single-beat read followed immediately by a write
      push_rd(16'h00A0, 1'b1);
      send_cmd(1'b0, 10'h3FE, 8'd0);
      write_burst(10'h200, 1, 16'h00C0, -1);
      wait_idle();
      push_rd(16'h00C0, 1'b0); push_rd(16'h00C1, 1'b1);
      send_cmd(1'b0, 10'h200, 8'd1);
      wait_idle();

      // Reset with read beats buffered: they must be discarded
      rdata_ready = 1'b0;
      send_cmd(1'b0, 10'h100, 8'd7);
      repeat (6) tick();
      chk("rrd_buffered", 32'(rdata_valid), 32'h1);
      reset = 1'b1;
      tick();
      chk("rrd_valid_cleared", 32'(rdata_valid), 32'h0);
      chk("rrd_busy_cleared", 32'(busy), 32'h0);
      reset = 1'b0;
      rdata_ready = 1'b1;
      tick();
      chk("rrd_no_stale", 32'(rdata_valid), 32'h0);

      // 5: reset during beat 2 of a len=5 write
      send_cmd(1'b1, 10'h300, 8'd5);
      write_beat(10'h300, 16'hD000);
      write_beat(10'h301, 16'hD001);
      wdata_valid = 1'b1;
      wdata = 16'hD002;
      reset = 1'b1;
      @(negedge clk);
      chk("t5_wr_en_in_reset", 32'(mem_wr_en), 32'h0);
      tick();
      chk("t5_mem_addr", 32'(mem_addr), 32'h0);
      chk("t5_wdata_ready", 32'(wdata_ready), 32'h0);
      chk("t5_mem_rd", 32'(mem_rd), 32'h0);
      chk("t5_busy", 32'(busy), 32'h0);
      chk("t5_rdata_valid", 32'(rdata_valid), 32'h0);
      chk("t5_cmd_ready", 32'(cmd_ready), 32'h1);
      reset = 1'b0;
      wdata_valid = 1'b0;
      tick();
      write_burst(10'h301, 0, 16'h00E0, -1);
      push_rd(16'hD000, 1'b0); push_rd(16'h00E0, 1'b0); push_rd(16'h0000, 1'b1);
      send_cmd(1'b0, 10'h300, 8'd2);
      wait_idle();

`ifdef SPMEM_CTRL_STATS_EN
      // 6: beat counters
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      write_burst(10'h010, 9, 16'h0F00, -1);
      for (int i = 0; i < 5; i++) push_rd(16'h0F00 + 16'(i), i == 4);
      send_cmd(1'b0, 10'h010, 8'd4);
      wait_idle();
      chk("t6_wr_beats", 32'(wr_beats), 32'd10);
      chk("t6_rd_beats", 32'(rd_beats), 32'd5);
`endif

      chk("end_rq_empty", 32'(rq.size()), 32'd0);
      chk("end_wq_empty", 32'(wq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
